// File: rtl/dbg_hex_pager.sv
// Debug word pager: shows two NUM_WORDS debug words per page on eight 7-segment digits,
// with debounced page-advance and freeze/snapshot pushbuttons.
module dbg_hex_pager #(
  parameter int unsigned NUM_WORDS    = 4,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned DEBOUNCE_CYC = 65536
) (
  input  logic                                                dbg_clk_i,
  input  logic                                                dbg_rstn_i,
  input  logic [NUM_WORDS*WORD_W-1:0]                         dbg_words_i,
  input  logic                                                dbg_nextn_i,
  input  logic                                                dbg_freezen_i,
  output logic [2*(WORD_W/4)*7-1:0]                           dbg_seg_o,
  output logic [(((NUM_WORDS/2) > 1) ? $clog2(NUM_WORDS/2) : 1)-1:0] dbg_page_o,
  output logic                                                dbg_frozen_o
);

  localparam int unsigned NUM_PAGES = NUM_WORDS / 2;
  localparam int unsigned DIGITS    = WORD_W / 4;
  localparam int unsigned SEG_W     = 2 * DIGITS * 7;
  localparam int unsigned PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

  // Button index 0 = next, 1 = freeze.
  logic [1:0]                    btn_raw;
  logic [1:0]                    sync1_q, sync2_q, lvl_q, pulse_q;
  logic [CNT_W-1:0]              cnt_q [2];

  logic [NUM_WORDS*WORD_W-1:0]   live_q, snap_q, sel_w;
  logic [PAGE_W-1:0]             page_q, page_nxt;
  logic                          frozen_q;
  logic [WORD_W-1:0]             lo_w, hi_w;
  logic [SEG_W-1:0]              seg_q, seg_d;

  assign btn_raw = {dbg_freezen_i, dbg_nextn_i};

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Accepted level flips only after DEBOUNCE_CYC consecutive differing samples;
  // the press pulse fires on the same edge the accepted level falls.
  always_ff @(posedge dbg_clk_i or negedge dbg_rstn_i) begin
    if (!dbg_rstn_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
      lvl_q   <= '1;
      pulse_q <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int unsigned i = 0; i < 2; i++) begin
        pulse_q[i] <= 1'b0;
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          lvl_q[i]   <= sync2_q[i];
          cnt_q[i]   <= '0;
          pulse_q[i] <= lvl_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    page_nxt = '0;
    if (NUM_PAGES > 1 && page_q != PAGE_LAST) page_nxt = page_q + PAGE_W'(1);
  end

  always_ff @(posedge dbg_clk_i or negedge dbg_rstn_i) begin
    if (!dbg_rstn_i) begin
      live_q   <= '0;
      snap_q   <= '0;
      page_q   <= '0;
      frozen_q <= 1'b0;
      seg_q    <= '1;
    end else begin
      live_q <= dbg_words_i;
      seg_q  <= seg_d;
      if (pulse_q[0]) page_q <= page_nxt;
      if (pulse_q[1]) begin
        frozen_q <= ~frozen_q;
        if (!frozen_q) snap_q <= live_q;
      end
    end
  end

  always_comb begin
    sel_w = frozen_q ? snap_q : live_q;
    lo_w  = '0;
    hi_w  = '0;
    seg_d = '1;
    for (int unsigned p = 0; p < NUM_PAGES; p++) begin
      if (page_q == PAGE_W'(p)) begin
        lo_w = sel_w[2*p*WORD_W +: WORD_W];
        hi_w = sel_w[(2*p+1)*WORD_W +: WORD_W];
      end
    end
    for (int unsigned d = 0; d < DIGITS; d++) begin
      seg_d[d*7 +: 7]          = hex7(lo_w[d*4 +: 4]);
      seg_d[(DIGITS+d)*7 +: 7] = hex7(hi_w[d*4 +: 4]);
    end
  end

  assign dbg_seg_o    = seg_q;
  assign dbg_page_o   = page_q;
  assign dbg_frozen_o = frozen_q;

endmodule

// File: tb/tb_dbg_hex_pager.sv
// Self-checking bench for dbg_hex_pager: cycle-level reference model plus directed and random stimulus.
module tb_dbg_hex_pager;

  localparam int NW  = 4;
  localparam int WW  = 16;
  localparam int DEB = 4;
  localparam int NP  = NW / 2;
  localparam int ND  = WW / 4;
  localparam int SW  = 2 * ND * 7;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW*WW-1:0]  words = '0;
  logic              nextn = 1'b1;
  logic              freezen = 1'b1;
  logic [SW-1:0]     seg;
  logic              page;
  logic              frozen;

  dbg_hex_pager #(.NUM_WORDS(NW), .WORD_W(WW), .DEBOUNCE_CYC(DEB)) dut (
    .dbg_clk_i    (clk),
    .dbg_rstn_i   (rst_n),
    .dbg_words_i  (words),
    .dbg_nextn_i  (nextn),
    .dbg_freezen_i(freezen),
    .dbg_seg_o    (seg),
    .dbg_page_o   (page),
    .dbg_frozen_o (frozen)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: words, page, freeze and buttons described as plain arithmetic
  int        m_page;
  bit        m_frozen;
  int        m_live [NW];
  int        m_snap [NW];
  bit        m_s1 [2], m_s2 [2], m_acc [2], m_pulse [2];
  int        m_run [2];
  logic [SW-1:0] m_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_page = 0; m_frozen = 0; m_seg = '1;
      for (int k = 0; k < NW; k++) begin m_live[k] = 0; m_snap[k] = 0; end
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_acc[b] = 1; m_pulse[b] = 0; m_run[b] = 0;
      end
    end else begin
      for (int d = 0; d < 2 * ND; d++) begin
        int w;
        w = m_frozen ? m_snap[2 * m_page + d / ND] : m_live[2 * m_page + d / ND];
        m_seg[d*7 +: 7] = HEX[(w >> (4 * (d % ND))) & 15];
      end
      if (m_pulse[1] && !m_frozen) for (int k = 0; k < NW; k++) m_snap[k] = m_live[k];
      if (m_pulse[1]) m_frozen = !m_frozen;
      if (m_pulse[0]) m_page = (m_page + 1) % NP;
      for (int k = 0; k < NW; k++) m_live[k] = int'(words[k*WW +: WW]);
      for (int b = 0; b < 2; b++) begin
        bit raw;
        raw = (b == 0) ? nextn : freezen;
        m_pulse[b] = 0;
        if (m_s2[b] == m_acc[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_acc[b] = m_s2[b];
            m_run[b] = 0;
            m_pulse[b] = (m_acc[b] == 0);
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("seg", 64'(seg), 64'(m_seg));
      check("page", 64'(page), 64'(m_page));
      check("frozen", 64'(frozen), 64'(m_frozen));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit nx, input bit fz, input int hold, input int gap);
    if (nx) nextn = 1'b0;
    if (fz) freezen = 1'b0;
    cyc(hold);
    nextn = 1'b1;
    freezen = 1'b1;
    cyc(gap);
  endtask

  task automatic reset_now();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    check("rst_page", 64'(page), 64'd0);
    check("rst_frozen", 64'(frozen), 64'd0);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    reset_now();
    cyc(2);
    rst_n = 1'b1;
    words = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678};
    cyc(3);
    check("lit_page0", 64'(seg), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

    press(1, 0, 10, 10);
    check("lit_page1", 64'(page), 64'd1);
    check("lit_page1_seg", 64'(seg), 64'({7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
    press(1, 0, 10, 10);
    check("lit_wrap", 64'(page), 64'd0);
    press(1, 0, 10, 10);
    check("lit_page1b", 64'(page), 64'd1);

    press(1, 0, 3, 10);
    check("lit_glitch", 64'(page), 64'd1);
    press(1, 0, 5, 10);
    check("lit_after_glitch", 64'(page), 64'd0);

    press(0, 1, 10, 2);
    words[15:0] = 16'hAAAA;
    cyc(8);
    check("lit_frozen", 64'(frozen), 64'd1);
    check("lit_frozen_seg", 64'(seg[27:0]), 64'({7'h12, 7'h02, 7'h78, 7'h00}));
    press(0, 1, 10, 10);
    check("lit_unfrozen", 64'(frozen), 64'd0);
    check("lit_unfrozen_seg", 64'(seg[27:0]), 64'({4{7'h08}}));

    press(1, 0, 10, 10);
    press(1, 1, 10, 10);
    check("lit_simul_page", 64'(page), 64'd0);
    check("lit_simul_frozen", 64'(frozen), 64'd1);
    words = {16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    press(1, 0, 10, 10);
    check("lit_frozen_page1", 64'(seg), 64'({7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
    press(0, 1, 10, 10);

    press(1, 0, 10, 10);
    @(negedge clk);
    nextn = 1'b0;
    cyc(2);
    reset_now();
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    check("lit_held_reset", 64'(page), 64'd1);
    nextn = 1'b1;
    cyc(10);
    check("lit_held_release", 64'(page), 64'd1);

    for (int it = 0; it < 120; it++) begin
      words = {$urandom, $urandom};
      nextn = ($urandom_range(0, 2) != 0);
      freezen = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 8));
    end
    nextn = 1'b1;
    freezen = 1'b1;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
